// File: rtl/ddr_ctrl_burst_bridge.sv
// Bridge from the single-master access interface to the DDR controller local (Avalon burst) port.
// Issues aligned multi-beat read/write bursts; a read watchdog recovers from lost read data.
module ddr_ctrl_burst_bridge #(
  parameter int unsigned ADDR_WIDTH     = 25,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_BURST_LOG2 = 4,
  parameter int unsigned TIMEOUT        = 1024
) (
  input  logic                                     local_clk_i,
  input  logic                                     local_reset_n_i,
  input  logic                                     acc_i,
  input  logic                                     we_i,
  input  logic [31:0]                              adr_i,
  input  logic [DATA_WIDTH-1:0]                    dat_i,
  input  logic [DATA_WIDTH/8-1:0]                  sel_i,
  input  logic [3:0]                               buf_width_i,
  output logic                                     ack_o,
  output logic [DATA_WIDTH-1:0]                    dat_o,
  output logic [31:0]                              adr_o,
  output logic                                     idle_o,
  output logic                                     rdy_o,
  output logic                                     err_o,
  output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0] local_address_o,
  output logic                                     local_write_req_o,
  output logic                                     local_read_req_o,
  output logic                                     local_burstbegin_o,
  output logic [DATA_WIDTH-1:0]                    local_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                  local_be_o,
  output logic [MAX_BURST_LOG2:0]                  local_size_o,
  input  logic [DATA_WIDTH-1:0]                    local_rdata_i,
  input  logic                                     local_rdata_valid_i,
  input  logic                                     local_ready_i
);

  localparam int unsigned Bw   = DATA_WIDTH / 8;
  localparam int unsigned Woff = $clog2(Bw);
  localparam int unsigned Aw   = ADDR_WIDTH - Woff;
  localparam int unsigned Sw   = MAX_BURST_LOG2 + 1;
  localparam int unsigned Btw  = (MAX_BURST_LOG2 > 0) ? MAX_BURST_LOG2 : 1;
  localparam int unsigned Wdw  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    StWaitReady,
    StIdle,
    StWrBeat,
    StWrFetch,
    StRdReq,
    StRdData
  } state_e;

  state_e              state_q;
  logic [Btw-1:0]      beat_q;
  logic [Wdw-1:0]      wd_q;
  logic [Aw-1:0]       address_q;
  logic [Sw-1:0]       size_q;
  logic                write_req_q, read_req_q, burstbegin_q, err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [Bw-1:0]       be_q;

  logic [3:0]          eff_l;
  logic [Sw-1:0]       start_size;
  logic [Aw-1:0]       start_word;
  logic [Btw-1:0]      beat_mask;
  logic [Aw-1:0]       cur_word;
  logic                unused_adr;

  assign eff_l      = (buf_width_i > 4'(MAX_BURST_LOG2)) ? 4'(MAX_BURST_LOG2) : buf_width_i;
  assign start_size = Sw'(1) << eff_l;
  assign start_word = adr_i[ADDR_WIDTH-1:Woff] & ~(Aw'(start_size) - Aw'(1));
  assign beat_mask  = Btw'(size_q - Sw'(1));
  // Window start has its low L bits clear, so OR-ing the beat offset never carries.
  assign cur_word   = address_q | Aw'(beat_q & beat_mask);
  assign unused_adr = ^adr_i;

  always_ff @(posedge local_clk_i or negedge local_reset_n_i) begin
    if (!local_reset_n_i) begin
      state_q      <= StWaitReady;
      beat_q       <= '0;
      wd_q         <= '0;
      address_q    <= '0;
      size_q       <= Sw'(1);
      write_req_q  <= 1'b0;
      read_req_q   <= 1'b0;
      burstbegin_q <= 1'b0;
      err_q        <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        StWaitReady: if (local_ready_i) state_q <= StIdle;
        StIdle: begin
          if (acc_i && local_ready_i) begin
            address_q    <= start_word;
            size_q       <= start_size;
            beat_q       <= '0;
            burstbegin_q <= 1'b1;
            if (we_i) begin
              write_req_q <= 1'b1;
              wdata_q     <= dat_i;
              be_q        <= sel_i;
              state_q     <= StWrBeat;
            end else begin
              read_req_q <= 1'b1;
              state_q    <= StRdReq;
            end
          end
        end
        StWrBeat: begin
          if (local_ready_i) begin
            write_req_q  <= 1'b0;
            burstbegin_q <= 1'b0;
            if (beat_q == beat_mask) begin
              state_q <= StIdle;
            end else begin
              beat_q  <= beat_q + Btw'(1);
              state_q <= StWrFetch;
            end
          end
        end
        StWrFetch: begin
          // An abandoned burst is completed with byte-disabled padding beats.
          write_req_q <= 1'b1;
          wdata_q     <= dat_i;
          be_q        <= (acc_i && we_i) ? sel_i : '0;
          state_q     <= StWrBeat;
        end
        StRdReq: begin
          if (local_ready_i) begin
            read_req_q   <= 1'b0;
            burstbegin_q <= 1'b0;
            wd_q         <= '0;
            state_q      <= StRdData;
          end
        end
        StRdData: begin
          if (local_rdata_valid_i) begin
            wd_q   <= '0;
            beat_q <= beat_q + Btw'(1);
            if (beat_q == beat_mask) state_q <= StIdle;
          end else if (TIMEOUT != 0) begin
            if (wd_q == Wdw'(TIMEOUT - 1)) begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end else begin
              wd_q <= wd_q + Wdw'(1);
            end
          end
        end
        default: state_q <= StWaitReady;
      endcase
    end
  end

  always_comb begin
    ack_o = 1'b0;
    case (state_q)
      StWrBeat: ack_o = acc_i & we_i & local_ready_i;
      StRdData: ack_o = acc_i & local_rdata_valid_i;
      default:  ack_o = 1'b0;
    endcase
  end

  assign dat_o              = local_rdata_i;
  assign adr_o              = 32'(cur_word) << Woff;
  assign idle_o             = (state_q == StIdle);
  assign rdy_o              = local_ready_i;
  assign err_o              = err_q;
  assign local_address_o    = address_q;
  assign local_write_req_o  = write_req_q;
  assign local_read_req_o   = read_req_q;
  assign local_burstbegin_o = burstbegin_q;
  assign local_wdata_o      = wdata_q;
  assign local_be_o         = be_q;
  assign local_size_o       = size_q;

endmodule

// File: tb/tb_ddr_ctrl_burst_bridge.sv
// Directed bench for ddr_ctrl_burst_bridge: write/read bursts, padding, watchdog and async reset.
module tb_ddr_ctrl_burst_bridge;

  localparam int unsigned Timeout = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        acc, we;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic [3:0]  bw;
  logic        ack_o;
  logic [31:0] dat_o, adr_o;
  logic        idle_o, rdy_o, err_o;
  logic [22:0] l_address;
  logic        l_wreq, l_rreq, l_bb;
  logic [31:0] l_wdata;
  logic [3:0]  l_be;
  logic [4:0]  l_size;
  logic [31:0] rdata;
  logic        rvalid, ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ddr_ctrl_burst_bridge #(
    .ADDR_WIDTH(25), .DATA_WIDTH(32), .MAX_BURST_LOG2(4), .TIMEOUT(Timeout)
  ) dut (
    .local_clk_i(clk), .local_reset_n_i(rst_n),
    .acc_i(acc), .we_i(we), .adr_i(adr), .dat_i(dat), .sel_i(sel), .buf_width_i(bw),
    .ack_o(ack_o), .dat_o(dat_o), .adr_o(adr_o), .idle_o(idle_o), .rdy_o(rdy_o), .err_o(err_o),
    .local_address_o(l_address), .local_write_req_o(l_wreq), .local_read_req_o(l_rreq),
    .local_burstbegin_o(l_bb), .local_wdata_o(l_wdata), .local_be_o(l_be),
    .local_size_o(l_size), .local_rdata_i(rdata), .local_rdata_valid_i(rvalid),
    .local_ready_i(ready)
  );

  task automatic test_reset;
    int idle_seen = 0;
    rst_n = 1'b0; ready = 1'b0; acc = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0; bw = '0;
    rdata = '0; rvalid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (l_wreq !== 1'b0 || l_rreq !== 1'b0 || l_bb !== 1'b0) begin bad++;
      $display("FAIL reset_req: got w=%b r=%b bb=%b want 0 0 0", l_wreq, l_rreq, l_bb); end
    total++; if (l_size !== 5'd1) begin bad++; $display("FAIL reset_size: got %0d want 1", l_size); end
    total++; if (l_address !== '0 || l_wdata !== '0 || l_be !== '0 || adr_o !== '0) begin bad++;
      $display("FAIL reset_data: got a=%h d=%h be=%h adr=%h want 0", l_address, l_wdata, l_be, adr_o); end
    total++; if (err_o !== 1'b0 || idle_o !== 1'b0) begin bad++;
      $display("FAIL reset_flags: got err=%b idle=%b want 0 0", err_o, idle_o); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (idle_o) idle_seen++; end
    total++; if (idle_seen !== 0) begin bad++; $display("FAIL wait_ready: got idle %0d times want 0", idle_seen); end
    @(posedge clk); #1 ready = 1'b1;
    @(negedge clk);
    total++; if (rdy_o !== 1'b1) begin bad++; $display("FAIL rdy_o: got %b want 1", rdy_o); end
    @(negedge clk);
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL reach_idle: got %b want 1", idle_o); end
    @(posedge clk); #1;
  endtask

  // Master holds acc until drop_after acks; each ack makes it present the next data word.
  task automatic test_write(input string name, input logic [31:0] a, input logic [3:0] w,
                            input int nexp, input int drop_after, input logic [22:0] exp_word,
                            input logic [4:0] exp_size, input logic [31:0] base);
    int k = 0, nbeat = 0, nack = 0;
    bit done = 0;
    logic prev_ack;
    logic [31:0] exp_adr;
    acc = 1'b1; we = 1'b1; adr = a; bw = w; dat = base; sel = 4'hF;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      @(negedge clk);
      prev_ack = ack_o;
      if (ack_o) nack++;
      if (l_wreq) begin
        exp_adr = {7'd0, exp_word, 2'b00} + 32'(nbeat) * 4;
        total++; if (l_address !== exp_word || l_size !== exp_size) begin bad++;
          $display("FAIL %s beat%0d addr/size: got %h/%0d want %h/%0d", name, nbeat, l_address,
                   l_size, exp_word, exp_size); end
        total++; if (l_bb !== (nbeat == 0)) begin bad++;
          $display("FAIL %s beat%0d burstbegin: got %b want %b", name, nbeat, l_bb, nbeat == 0); end
        total++; if (adr_o !== exp_adr) begin bad++;
          $display("FAIL %s beat%0d adr_o: got %h want %h", name, nbeat, adr_o, exp_adr); end
        total++; if (l_be !== ((nbeat < drop_after) ? 4'hF : 4'h0)) begin bad++;
          $display("FAIL %s beat%0d be: got %h want %h", name, nbeat, l_be,
                   (nbeat < drop_after) ? 4'hF : 4'h0); end
        total++; if (ack_o !== (nbeat < drop_after)) begin bad++;
          $display("FAIL %s beat%0d ack: got %b want %b", name, nbeat, ack_o, nbeat < drop_after); end
        if (nbeat < drop_after) begin
          total++; if (l_wdata !== base + 32'(nbeat)) begin bad++;
            $display("FAIL %s beat%0d wdata: got %h want %h", name, nbeat, l_wdata, base + 32'(nbeat)); end
        end
        nbeat++;
      end else if (nbeat > 0 && idle_o) begin
        done = 1;
      end
      @(posedge clk); #1;
      if (prev_ack) begin
        k++; dat = base + 32'(k);
        if (k >= drop_after) acc = 1'b0;
      end
    end
    total++; if (!done || nbeat != nexp) begin bad++;
      $display("FAIL %s beats: got %0d (idle=%0b) want %0d", name, nbeat, done, nexp); end
    total++; if (nack != ((drop_after < nexp) ? drop_after : nexp)) begin bad++;
      $display("FAIL %s acks: got %0d want %0d", name, nack, (drop_after < nexp) ? drop_after : nexp); end
    acc = 1'b0;
  endtask

  task automatic test_back_to_back;
    acc = 1'b1; we = 1'b1; adr = 32'h100; bw = 4'd0; dat = 32'hA1A1_A1A1; sel = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (ack_o !== 1'b1) begin bad++; $display("FAIL b2b_ack1: got %b want 1", ack_o); end
    @(posedge clk); #1 adr = 32'h104; dat = 32'hB2B2_B2B2;
    @(negedge clk);
    total++; if (idle_o !== 1'b1 || l_wreq !== 1'b0) begin bad++;
      $display("FAIL b2b_idle: got idle=%b wreq=%b want 1 0", idle_o, l_wreq); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (l_wreq !== 1'b1 || l_bb !== 1'b1 || l_address !== 23'h41 || l_wdata !== 32'hB2B2_B2B2) begin
      bad++; $display("FAIL b2b_second: got w=%b bb=%b a=%h d=%h want 1 1 41 b2b2b2b2",
                      l_wreq, l_bb, l_address, l_wdata); end
    @(posedge clk); #1 acc = 1'b0;
    @(negedge clk);
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL b2b_end_idle: got %b want 1", idle_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_read;
    int held = 0;
    acc = 1'b1; we = 1'b0; adr = 32'h1C; bw = 4'd3; ready = 1'b1;
    @(negedge clk);
    total++; if (ack_o !== 1'b0) begin bad++; $display("FAIL rd_idle_ack: got %b want 0", ack_o); end
    @(posedge clk); #1 ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); if (l_rreq) held++;
      @(posedge clk); #1;
    end
    ready = 1'b1;
    @(negedge clk); if (l_rreq) held++;
    total++; if (held != 4) begin bad++; $display("FAIL rd_req_hold: got %0d cycles want 4", held); end
    total++; if (l_size !== 5'd8 || l_address !== 23'h0 || l_bb !== 1'b1) begin bad++;
      $display("FAIL rd_req_fields: got size=%0d a=%h bb=%b want 8 0 1", l_size, l_address, l_bb); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (l_rreq !== 1'b0 || l_bb !== 1'b0) begin bad++;
      $display("FAIL rd_req_clear: got r=%b bb=%b want 0 0", l_rreq, l_bb); end
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      rvalid = 1'b1; rdata = 32'hBEEF_0000 + 32'(k);
      @(negedge clk);
      total++; if (ack_o !== 1'b1 || dat_o !== 32'hBEEF_0000 + 32'(k) || adr_o !== 32'(k) * 4) begin
        bad++; $display("FAIL rd_beat%0d: got ack=%b d=%h adr=%h want 1 %h %h", k, ack_o, dat_o,
                        adr_o, 32'hBEEF_0000 + 32'(k), 32'(k) * 4); end
      @(posedge clk); #1 rvalid = 1'b0; rdata = '0;
      if (k == 7) acc = 1'b0;
      if (k % 2 == 1 && k < 7) begin
        @(negedge clk);
        total++; if (ack_o !== 1'b0 || idle_o !== 1'b0) begin bad++;
          $display("FAIL rd_gap%0d: got ack=%b idle=%b want 0 0", k, ack_o, idle_o); end
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL rd_end_idle: got %b want 1", idle_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    int early = 0;
    acc = 1'b1; we = 1'b0; adr = 32'h400; bw = 4'd7; ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (l_size !== 5'd16 || l_address !== 23'h100) begin bad++;
      $display("FAIL to_clamp: got size=%0d a=%h want 16 100", l_size, l_address); end
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      rvalid = 1'b1; rdata = 32'h5A5A_0000 + 32'(k);
      @(negedge clk);
      total++; if (ack_o !== 1'b1 || adr_o !== 32'h400 + 32'(k) * 4) begin bad++;
        $display("FAIL to_beat%0d: got ack=%b adr=%h want 1 %h", k, ack_o, adr_o, 32'h400 + 32'(k) * 4); end
      @(posedge clk); #1;
    end
    rvalid = 1'b0; acc = 1'b0;
    for (int j = 0; j <= int'(Timeout); j++) begin
      @(negedge clk);
      if (j < int'(Timeout)) begin
        if (err_o || idle_o) early++;
      end else begin
        total++; if (err_o !== 1'b1 || idle_o !== 1'b1) begin bad++;
          $display("FAIL to_err: got err=%b idle=%b want 1 1", err_o, idle_o); end
      end
    end
    total++; if (early != 0) begin bad++; $display("FAIL to_early: got %0d cycles want 0", early); end
    @(negedge clk);
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL to_pulse: got %b want 0", err_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst;
    int idle_seen = 0;
    acc = 1'b1; we = 1'b1; adr = 32'h20C; bw = 4'd2; dat = 32'h7777_0000; sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1 dat = 32'h7777_0001;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (l_wreq !== 1'b1) begin bad++; $display("FAIL rst_pre: got wreq=%b want 1", l_wreq); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (l_wreq !== 1'b0 || l_rreq !== 1'b0 || l_bb !== 1'b0 || l_size !== 5'd1) begin bad++;
      $display("FAIL rst_async: got w=%b r=%b bb=%b size=%0d want 0 0 0 1", l_wreq, l_rreq, l_bb, l_size); end
    total++; if (l_be !== '0 || l_address !== '0 || adr_o !== '0 || ack_o !== 1'b0 || idle_o !== 1'b0) begin
      bad++; $display("FAIL rst_async_data: got be=%h a=%h adr=%h ack=%b idle=%b want 0", l_be,
                      l_address, adr_o, ack_o, idle_o); end
    acc = 1'b0; ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (idle_o) idle_seen++; end
    total++; if (idle_seen != 0) begin bad++; $display("FAIL rst_wait: got idle %0d times want 0", idle_seen); end
    @(posedge clk); #1 ready = 1'b1;
    @(negedge clk); @(negedge clk);
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL rst_recover: got %b want 1", idle_o); end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_write("wr_single", 32'h100, 4'd0, 1, 1, 23'h40, 5'd1, 32'hCAFE_F00D);
    test_write("wr_burst", 32'h20C, 4'd2, 4, 4, 23'h80, 5'd4, 32'h1000_0000);
    test_write("wr_drop", 32'h20C, 4'd2, 4, 2, 23'h80, 5'd4, 32'h2000_0000);
    test_back_to_back();
    test_read();
    test_timeout();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_ctrl_burst_bridge.md
# ddr_ctrl_burst_bridge

Parametrised bridge between the internal single-master access interface and the Altera DDR controller local (Avalon burst) port. It generalises data width and maximum burst length, and issues true multi-beat write bursts as well as read bursts. Write bursts are padded with disabled byte enables if the master abandons them. A read-timeout watchdog flags and recovers from lost read data. It sits between the Wishbone-side cache/buffer logic and the DDR controller, in the `local_clk_i` domain.

## Interface
- `ADDR_WIDTH`, 25: byte-address bits of DDR (memory = 2^ADDR_WIDTH bytes).
- `DATA_WIDTH`, 32: local data width; multiple of 8, power of two. BW = DATA_WIDTH/8, WOFF = log2(BW).
- `MAX_BURST_LOG2`, 4: largest burst = 2^MAX_BURST_LOG2 beats.
- `TIMEOUT`, 1024: cycles allowed between read beats; 0 disables the watchdog.

Ports:
- `local_clk_i` in 1: the single clock.
- `local_reset_n_i` in 1: reset, asynchronous assert, active-low.
- `acc_i` in 1: access request/hold. `we_i` in 1: 1 = write.
- `adr_i` in 32: byte address.
- `dat_i` in DATA_WIDTH: write data. `sel_i` in BW: byte selects.
- `buf_width_i` in 4: log2 of burst beats.
- `ack_o` out 1: beat acknowledge. `dat_o` out DATA_WIDTH: read data (= `local_rdata_i`).
- `adr_o` out 32: byte address of current beat.
- `idle_o` out 1: FSM in IDLE. `rdy_o` out 1: equals `local_ready_i`.
- `err_o` out 1: one-cycle pulse on read timeout.
- `local_address_o` out ADDR_WIDTH-WOFF: word address.
- `local_write_req_o` out 1, `local_read_req_o` out 1, `local_burstbegin_o` out 1.
- `local_wdata_o` out DATA_WIDTH, `local_be_o` out BW.
- `local_size_o` out MAX_BURST_LOG2+1: burst beats.
- `local_rdata_i` in DATA_WIDTH, `local_rdata_valid_i` in 1, `local_ready_i` in 1.

## Operation
- **Reset values:** all local req/burstbegin 0; `local_address_o`, `local_wdata_o`, `local_be_o`, `adr_o` 0; `local_size_o` 1; `err_o` 0; state WAIT_READY, so `idle_o` 0.
- All local-side outputs are registered. `ack_o`, `dat_o`, `rdy_o` and `idle_o` are combinational.
- **Burst sizing:**
  - Effective log2 burst L = min(`buf_width_i`, MAX_BURST_LOG2), latched at burst start; N = 2^L.
  - Start word = `adr_i`[ADDR_WIDTH-1:WOFF] with the low L bits cleared.
  - `adr_o` = start word × BW, then advances by BW per beat; offset wraps modulo N×BW inside the window.
- **States:** WAIT_READY, IDLE, WR_BEAT, WR_FETCH, RD_REQ, RD_DATA.
- **WAIT_READY → IDLE:** when `local_ready_i`.
- **IDLE, `acc_i` & `local_ready_i`, write:**
  - Load address and size; `local_wdata_o`=`dat_i`, `local_be_o`=`sel_i`.
  - Set `local_write_req_o`=1 and `local_burstbegin_o`=1; beat=0; → WR_BEAT.
- **IDLE, `acc_i` & `local_ready_i`, read:**
  - Load address and size; set `local_read_req_o`=1 and `local_burstbegin_o`=1; beat=0; → RD_REQ.
- **WR_BEAT:**
  - Beat accepted on an edge with `local_ready_i`=1.
  - `ack_o` = `acc_i` & `we_i` & `local_ready_i`.
  - On accept: clear req and burstbegin. If beat = N-1 → IDLE; else beat+1, advance `adr_o`, → WR_FETCH.
- **WR_FETCH:**
  - Set `local_write_req_o`=1; `local_wdata_o`=`dat_i`.
  - `local_be_o` = `sel_i` if `acc_i`&`we_i`, else all zeros (padding beat, never acked). → WR_BEAT.
  - `local_address_o` is constant for the whole burst.
- **RD_REQ:** on an edge with `local_ready_i`, clear `local_read_req_o` and `local_burstbegin_o`; → RD_DATA.
- **RD_DATA:**
  - `ack_o` = `acc_i` & `local_rdata_valid_i`.
  - Each valid beat: beat+1 and `adr_o` advances. After beat N-1 is received → IDLE.
  - If `acc_i` drops, remaining beats are still drained, without ack.
- **Watchdog:**
  - Counter clears on entering RD_DATA and on each valid beat; it counts other RD_DATA cycles.
  - Reaching TIMEOUT: `err_o`=1 for one cycle, → IDLE.
- `ack_o` is 0 in every state not listed above.

## Timing
- **Read latency:** request visible 1 cycle after the IDLE accept edge. Data acked in the same cycle `local_rdata_valid_i` is high.
- **Write throughput:** 1 beat per 2 cycles at best (WR_BEAT/WR_FETCH alternation).
  - After `ack_o` in cycle t, the master presents the next `dat_i` by edge t+1; the bridge captures it at edge t+2.
- **Boundaries:**
  - L > MAX_BURST_LOG2 is clamped.
  - L=0 gives a single beat with no wrap.
  - Last write beat returns to IDLE, so a new access can start on the next cycle.
- **Reset mid-burst:** all outputs return to reset values immediately (asynchronous). The FSM restarts in WAIT_READY and the partial burst is abandoned.

## Test plan
- Write, `buf_width_i`=0, `adr_i`=0x100, `dat_i`=0xCAFEF00D, ready=1:
  - One `local_write_req_o` with burstbegin, `local_address_o`=0x40, size=1, one `ack_o`.
  - `idle_o` returns 1 after 2 cycles.
- Write burst, `buf_width_i`=2, `adr_i`=0x20C:
  - `local_address_o`=0x80, size=4, burstbegin on beat 0 only, 4 acks.
  - `adr_o` = 0x200, 0x204, 0x208, 0x20C.
- Same write burst, `acc_i` dropped after 2nd ack: beats 3–4 issued with `local_be_o`=0 and no `ack_o`.
- Read, `buf_width_i`=3, `adr_i`=0x1C, `local_ready_i` low 3 cycles after request:
  - `local_read_req_o` held until ready; size=8.
  - 8 acks; `adr_o` steps 0x00..0x1C; then IDLE.
- Read, `buf_width_i`=7 with MAX_BURST_LOG2=4: size=16.
  - Model stops after 5 beats → `err_o` pulses exactly TIMEOUT cycles after the 5th beat; FSM in IDLE.
- Assert `local_reset_n_i` mid write burst:
  - All req outputs 0 asynchronously, `local_size_o`=1.
  - FSM waits in WAIT_READY until ready.
